// File: rtl/mult_div_unit_pkg.sv
// Shared constants for the HI/LO multiply-divide unit:
// op codes, state encoding and default latencies.
package mult_div_unit_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;

endpackage

// File: rtl/md_div_core.sv
// Combinational signed/unsigned 32-bit divider; ok drops on a zero divisor
// so the caller can leave HI/LO untouched.
module md_div_core (
    input  logic        sgn,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] quo,
    output logic [31:0] rem,
    output logic        ok
);

    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] uq;
    logic [31:0] ur;

    always_comb begin
        ok    = (b != 32'd0);
        a_neg = sgn & a[31];
        b_neg = sgn & b[31];
        a_mag = a_neg ? (~a + 32'd1) : a;
        // a zero divisor is replaced so the divider never sees it
        b_mag = !ok ? 32'd1 : (b_neg ? (~b + 32'd1) : b);
        uq    = a_mag / b_mag;
        ur    = a_mag % b_mag;
        quo   = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
        rem   = a_neg ? (~ur + 32'd1) : ur;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            quo = 32'h8000_0000;
            rem = 32'd0;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO registers;
// operands are latched at launch and results land after a fixed latency.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);
    localparam logic [3:0] DIV_CNT = 4'(DIV_LAT - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic signed [32:0] mul_a;
    logic signed [32:0] mul_b;
    logic signed [65:0] prod;
    logic [31:0]        div_q;
    logic [31:0]        div_r;
    logic               div_ok;

    // sign-extend to 33 bits so one signed multiplier covers both flavours
    always_comb begin
        mul_a = {(op_q == OP_MULT) & a_q[31], a_q};
        mul_b = {(op_q == OP_MULT) & b_q[31], b_q};
        prod  = mul_a * mul_b;
    end

    md_div_core u_div (
        .sgn (op_q == OP_DIV),
        .a   (a_q),
        .b   (b_q),
        .quo (div_q),
        .rem (div_r),
        .ok  (div_ok)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    case (Op)
                        OP_MULT, OP_MULTU: begin
                            state_d = ST_MUL;
                            cnt_d   = MUL_CNT;
                            op_d    = Op;
                            a_d     = A;
                            b_d     = B;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d = ST_DIV;
                            cnt_d   = DIV_CNT;
                            op_d    = Op;
                            a_d     = A;
                            b_d     = B;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                if (cnt_q == 4'd0) begin
                    hi_d    = prod[63:32];
                    lo_d    = prod[31:0];
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DIV: begin
                if (cnt_q == 4'd0) begin
                    if (div_ok) begin
                        hi_d = div_r;
                        lo_d = div_q;
                    end
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            op_q    <= OP_MULT;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign Busy = (state_q != ST_IDLE);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomised bench for mult_div_unit against a cycle-level behavioural
// model of HI/LO/Busy, plus literal checks of known results.
module tb_mult_div_unit;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic        clk;
    logic        rst;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int errors = 0;
    int checks = 0;

    mult_div_unit #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk   (clk),
        .rst   (rst),
        .Start (Start),
        .Op    (Op),
        .A     (A),
        .B     (B),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: remaining busy cycles and the pending result.
    int          m_rem;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [31:0] p_hi;
    logic [31:0] p_lo;
    logic        p_ok;

    function automatic void compute(input logic [2:0] op,
                                    input logic [31:0] a,
                                    input logic [31:0] b,
                                    output logic [31:0] hi,
                                    output logic [31:0] lo,
                                    output logic ok);
        longint      sp;
        logic [63:0] up;
        int          sa;
        int          sb;
        ok = 1'b1;
        hi = 32'd0;
        lo = 32'd0;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            3'd0: begin
                sp = longint'(sa) * longint'(sb);
                {hi, lo} = sp;
            end
            3'd1: begin
                up = {32'd0, a} * {32'd0, b};
                {hi, lo} = up;
            end
            3'd2: begin
                if (b == 32'd0) ok = 1'b0;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo = 32'h8000_0000;
                    hi = 32'd0;
                end else begin
                    lo = sa / sb;
                    hi = sa % sb;
                end
            end
            3'd3: begin
                if (b == 32'd0) ok = 1'b0;
                else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
            default: ok = 1'b0;
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin
        logic [31:0] h;
        logic [31:0] l;
        logic        k;
        if (!rst) begin
            m_rem <= 0;
            m_hi  <= 32'd0;
            m_lo  <= 32'd0;
            p_ok  <= 1'b0;
            p_hi  <= 32'd0;
            p_lo  <= 32'd0;
        end else if (m_rem > 0) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1 && p_ok) begin
                m_hi <= p_hi;
                m_lo <= p_lo;
            end
        end else if (Start) begin
            if (Op <= 3'd3) begin
                compute(Op, A, B, h, l, k);
                p_hi  <= h;
                p_lo  <= l;
                p_ok  <= k;
                m_rem <= (Op <= 3'd1) ? MUL_LAT : DIV_LAT;
            end else if (Op == 3'd4) begin
                m_hi <= A;
            end else if (Op == 3'd5) begin
                m_lo <= A;
            end
        end
    end

    always @(negedge clk) begin
        checks++;
        if (Busy !== (m_rem > 0) || HI !== m_hi || LO !== m_lo) begin
            errors++;
            $display("FAIL model t=%0t busy=%b/%b hi=%h/%h lo=%h/%h",
                     $time, Busy, (m_rem > 0), HI, m_hi, LO, m_lo);
        end
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, exp);
        end
    endtask

    task automatic pulse(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        @(posedge clk);
        #2;
        Start = 1'b1;
        Op    = op;
        A     = a;
        B     = b;
        @(posedge clk);
        #2;
        Start = 1'b0;
        A     = $urandom;
        B     = $urandom;
    endtask

    // counts Busy-high negedges; noisy drives random traffic while busy
    task automatic wait_idle(input bit noisy, output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!Busy) begin
                Start = 1'b0;
                return;
            end
            n++;
            if (noisy) begin
                Start = 1'($urandom);
                Op    = 3'($urandom);
                A     = $urandom;
                B     = $urandom;
            end
        end
        errors++;
        $display("FAIL timeout busy never dropped");
    endtask

    task automatic run(input string name, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input int lat, input logic [31:0] hi,
                       input logic [31:0] lo);
        int n;
        pulse(op, a, b);
        wait_idle(1'b0, n);
        chk({name, "_busy"}, 32'(n), 32'(lat));
        chk({name, "_hi"}, HI, hi);
        chk({name, "_lo"}, LO, lo);
    endtask

    initial begin
        int n;
        logic [31:0] ra;
        logic [31:0] rb;
        rst   = 1'b0;
        Start = 1'b0;
        Op    = 3'd0;
        A     = 32'd0;
        B     = 32'd0;
        #23;
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        rst = 1'b1;

        run("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, 5,
            32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run("multu", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,
            32'hFFFF_FFFE, 32'h0000_0001);
        run("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 10,
            32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run("mthi", 3'd4, 32'h1234, 32'd0, 0,
            32'h1234, 32'hFFFF_FFFD);
        run("mtlo", 3'd5, 32'h5678, 32'd0, 0,
            32'h1234, 32'h5678);
        run("divu0", 3'd3, 32'd99, 32'd0, 10,
            32'h1234, 32'h5678);
        run("ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10,
            32'd0, 32'h8000_0000);
        run("undef", 3'd7, 32'hDEAD, 32'hBEEF, 0,
            32'd0, 32'h8000_0000);

        pulse(3'd2, 32'd100, 32'd7);
        @(posedge clk);
        #2;
        Start = 1'b1;
        Op    = 3'd5;
        A     = 32'hAAAA;
        @(posedge clk);
        #2;
        Start = 1'b0;
        wait_idle(1'b0, n);
        chk("mtlo_busy_lo", LO, 32'd14);
        chk("mtlo_busy_hi", HI, 32'd2);

        pulse(3'd0, 32'd1000, 32'd1000);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("abort_busy", 32'(Busy), 32'd0);
        chk("abort_hi", HI, 32'd0);
        chk("abort_lo", LO, 32'd0);
        #8;
        rst = 1'b1;
        repeat (8) @(posedge clk);
        #2;
        chk("abort_late_hi", HI, 32'd0);
        chk("abort_late_lo", LO, 32'd0);
        chk("abort_late_busy", 32'(Busy), 32'd0);

        for (int i = 0; i < 80; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                3: rb = 32'($urandom_range(1, 9));
                default: ;
            endcase
            pulse(3'($urandom), ra, rb);
            wait_idle(1'b1, n);
        end
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
